// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared definitions for the multicycle stack-machine controller:
//   controller states, opcode constants, datapath select encodings and a
//   small opcode classifier used by the FSM.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    // Opcodes at the default 5-bit opcode width; HALT is all-ones.
    localparam logic [4:0] OP_APUT = 5'd0;
    localparam logic [4:0] OP_SPUT = 5'd1;
    localparam logic [4:0] OP_SPEK = 5'd4;
    localparam logic [4:0] OP_SPOP = 5'd5;
    localparam logic [4:0] OP_RPOP = 5'd6;
    localparam logic [4:0] OP_BKAC = 5'd21;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Memory address select.
    localparam logic [2:0] MEMSRC_PC      = 3'b000;
    localparam logic [2:0] MEMSRC_SP      = 3'b100;
    localparam logic [2:0] MEMSRC_SP_PEEK = 3'b101;

    // Mary register data select.
    localparam logic [1:0] MARYSRC_MEM  = 2'b00;
    localparam logic [1:0] MARYSRC_APUT = 2'b11;

    // Stack-pointer data select.
    localparam logic [1:0] SPSRC_PUSH = 2'b01;
    localparam logic [1:0] SPSRC_POP  = 2'b10;

    // Behavioural class of an opcode as seen by the EXEC/MEM states.
    typedef enum logic [2:0] {
        OPC_NOP  = 3'd0,
        OPC_APUT = 3'd1,
        OPC_PUSH = 3'd2,
        OPC_PEEK = 3'd3,
        OPC_SPOP = 3'd4,
        OPC_RPOP = 3'd5
    } op_class_e;

    function automatic op_class_e classify(input logic [31:0] op);
        op_class_e cls;
        cls = OPC_NOP;
        case (op)
            32'(OP_APUT):             cls = OPC_APUT;
            32'(OP_SPUT), 32'(OP_BKAC): cls = OPC_PUSH;
            32'(OP_SPEK):             cls = OPC_PEEK;
            32'(OP_SPOP):             cls = OPC_SPOP;
            32'(OP_RPOP):             cls = OPC_RPOP;
            default:                  cls = OPC_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_control_depth.sv
// ---------------------------------------------------------------------------
// stack_depth_counter
//   Saturating data-stack occupancy counter (0 .. STACK_DEPTH).
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     inc_i/dec_i  push / pop completed this cycle
//     full_o       occupancy == STACK_DEPTH
//     empty_o      occupancy == 0
//     depth_o      current occupancy
// ---------------------------------------------------------------------------
module stack_depth_counter #(
    parameter int STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc_i,
    input  logic                         dec_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(STACK_DEPTH):0] depth_o
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && !full_o) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM for a multicycle stack machine:
//   FETCH -> DECODE -> EXEC [-> MEM] -> FETCH, plus absorbing HALT/FAULT.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     OPCODE, flagbit       current instruction opcode and @ modifier
//     mem_ready             memory finishes the current access this cycle
//     PCWrite, IRWrite      PC / IR load strobes
//     MemRead, MemWrite     memory request strobes, MemSrc address select
//     MaryWrite, ShelleyWrite, SPWrite, RAWrite   register strobes
//     MarySrc, SPSrc        register data selects
//     busy                  high outside FETCH and HALT
//     fault                 sticky stack-fault flag
//     depth                 data-stack occupancy
//   Configuration macro: STACK_BOUNDS_CHECK_EN -- push on full / pop on empty
//   traps to FAULT instead of executing with a saturating depth.
// ---------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OPCODE_W-1:0]          OPCODE,
    input  logic                         flagbit,
    input  logic                         mem_ready,
    output logic                         PCWrite,
    output logic                         IRWrite,
    output logic                         MemRead,
    output logic                         MemWrite,
    output logic [2:0]                   MemSrc,
    output logic                         MaryWrite,
    output logic                         ShelleyWrite,
    output logic                         SPWrite,
    output logic                         RAWrite,
    output logic [1:0]                   MarySrc,
    output logic [1:0]                   SPSrc,
    output logic                         busy,
    output logic                         fault,
    output logic [$clog2(STACK_DEPTH):0] depth
);
    // HALT is the all-ones opcode at any opcode width.
    localparam logic [OPCODE_W-1:0] HALT_CODE = {OPCODE_W{OP_HALT[0]}};

    state_e    state_q;
    state_e    state_d;
    logic      run_q;
    op_class_e op_class;
    logic      stack_full;
    logic      stack_empty;
    logic      stack_inc;
    logic      stack_dec;
    logic      bounds_fault;

    assign op_class = classify(32'(OPCODE));

    stack_depth_counter #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_depth (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (stack_inc),
        .dec_i  (stack_dec),
        .full_o (stack_full),
        .empty_o(stack_empty),
        .depth_o(depth)
    );

`ifdef STACK_BOUNDS_CHECK_EN
    assign bounds_fault = ((op_class == OPC_PUSH) && stack_full) ||
                          (((op_class == OPC_SPOP) || (op_class == OPC_RPOP)) && stack_empty);
    assign fault = (state_q == S_FAULT);
`else
    logic unused_bounds;
    assign unused_bounds = stack_full | stack_empty;
    assign bounds_fault  = 1'b0;
    assign fault         = 1'b0;
`endif

    // run_q is cleared by reset and set by the first clock edge after it, so
    // the FETCH request starts on that edge rather than while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            state_q <= S_FETCH;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (run_q && mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (OPCODE == HALT_CODE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op_class)
                    OPC_PUSH, OPC_PEEK, OPC_SPOP, OPC_RPOP:
                        state_d = bounds_fault ? S_FAULT : S_MEM;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (mem_ready) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase
    end

    assign busy = (state_q != S_FETCH) && (state_q != S_HALT);

    // Memory-completion strobes are qualified by mem_ready in the same cycle,
    // which gives one pulse per instruction and one extra cycle per wait.
    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemSrc       = 3'b000;
        MaryWrite    = 1'b0;
        ShelleyWrite = 1'b0;
        SPWrite      = 1'b0;
        RAWrite      = 1'b0;
        MarySrc      = 2'b00;
        SPSrc        = 2'b00;
        stack_inc    = 1'b0;
        stack_dec    = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    MemSrc  = MEMSRC_PC;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (op_class == OPC_APUT) begin
                        if (flagbit) begin
                            ShelleyWrite = 1'b1;
                        end else begin
                            MaryWrite = 1'b1;
                            MarySrc   = MARYSRC_APUT;
                        end
                    end
                end
                S_MEM: begin
                    case (op_class)
                        OPC_PUSH: begin
                            MemWrite = 1'b1;
                            MemSrc   = MEMSRC_SP;
                            if (mem_ready) begin
                                SPWrite   = 1'b1;
                                SPSrc     = SPSRC_PUSH;
                                stack_inc = 1'b1;
                            end
                        end
                        OPC_PEEK: begin
                            MemRead = 1'b1;
                            MemSrc  = MEMSRC_SP_PEEK;
                            if (mem_ready) begin
                                MaryWrite = 1'b1;
                                MarySrc   = MARYSRC_MEM;
                            end
                        end
                        OPC_SPOP, OPC_RPOP: begin
                            MemRead = 1'b1;
                            MemSrc  = MEMSRC_SP;
                            if (mem_ready) begin
                                SPWrite   = 1'b1;
                                SPSrc     = SPSRC_POP;
                                stack_dec = 1'b1;
                                if (op_class == OPC_SPOP) begin
                                    MaryWrite = 1'b1;
                                    MarySrc   = MARYSRC_MEM;
                                end else begin
                                    RAWrite = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. The reference model describes
//   each instruction as a sequence of phases (fetch with waits, decode, exec,
//   memory with waits) and derives the expected outputs of every cycle and the
//   stack occupancy from that description.
// ---------------------------------------------------------------------------
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int OPCODE_W    = 5;
    localparam int STACK_DEPTH = 16;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic [2:0] msrc;
        logic       maryw;
        logic       shw;
        logic       spw;
        logic       raw;
        logic [1:0] marysrc;
        logic [1:0] spsrc;
        logic       busy;
        logic       fault;
    } sig_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [OPCODE_W-1:0] OPCODE = '0;
    logic                flagbit = 1'b0;
    logic                mem_ready = 1'b0;
    logic                PCWrite, IRWrite, MemRead, MemWrite;
    logic [2:0]          MemSrc;
    logic                MaryWrite, ShelleyWrite, SPWrite, RAWrite;
    logic [1:0]          MarySrc, SPSrc;
    logic                busy, fault;
    logic [DEPTH_W-1:0]  depth;

    int       errors = 0;
    int       checks = 0;
    int       model_depth = 0;
    int       cyc_no = 0;
    logic [4:0] cur_op = '0;
    logic       cur_flag = 1'b0;
    bit         fault_seen = 1'b0;

    multicycle_control #(
        .OPCODE_W   (OPCODE_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .OPCODE      (OPCODE),
        .flagbit     (flagbit),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSrc      (MemSrc),
        .MaryWrite   (MaryWrite),
        .ShelleyWrite(ShelleyWrite),
        .SPWrite     (SPWrite),
        .RAWrite     (RAWrite),
        .MarySrc     (MarySrc),
        .SPSrc       (SPSrc),
        .busy        (busy),
        .fault       (fault),
        .depth       (depth)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic sig_t observe();
        sig_t s;
        s = {PCWrite, IRWrite, MemRead, MemWrite, MemSrc, MaryWrite, ShelleyWrite,
             SPWrite, RAWrite, MarySrc, SPSrc, busy, fault};
        return s;
    endfunction

    // One clock cycle: drive inputs on the falling edge, sample 1 time unit later.
    task automatic step(input string tag, input logic rdy, input sig_t exp_s);
        sig_t got;
        @(negedge clk);
        OPCODE    = cur_op;
        flagbit   = cur_flag;
        mem_ready = rdy;
        #1;
        cyc_no++;
        got = observe();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL %s cyc=%0d outputs got=%h exp=%h", tag, cyc_no, got, exp_s);
        end
        checks++;
        if (depth !== DEPTH_W'(model_depth)) begin
            errors++;
            $display("FAIL %s cyc=%0d depth got=%0d exp=%0d", tag, cyc_no, depth, model_depth);
        end
    endtask

    // Reference model of one instruction: fw fetch wait cycles, mw memory wait cycles.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic flag,
                             input int fw, input int mw);
        sig_t e;
        bit   is_push, is_peek, is_pop, goes_mem, will_fault;
        cur_op   = op;
        cur_flag = flag;
        cyc_no   = 0;
        is_push  = (op == 5'd1) || (op == 5'd21);
        is_peek  = (op == 5'd4);
        is_pop   = (op == 5'd5) || (op == 5'd6);
        goes_mem = is_push || is_peek || is_pop;
        will_fault = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
        will_fault = (is_push && model_depth == STACK_DEPTH) || (is_pop && model_depth == 0);
`endif
        // fetch phase
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            e.mrd = 1'b1;
            if (i == fw) begin
                e.irw = 1'b1;
                e.pcw = 1'b1;
            end
            step(tag, (i == fw), e);
        end
        // decode phase
        e = '0;
        e.busy = 1'b1;
        step(tag, 1'($urandom), e);
        if (op == 5'b11111) begin
            for (int i = 0; i < 10; i++) begin
                e = '0;
                step(tag, 1'($urandom), e);
            end
            return;
        end
        // exec phase
        e = '0;
        e.busy = 1'b1;
        if (op == 5'd0) begin
            if (!flag) begin
                e.maryw   = 1'b1;
                e.marysrc = 2'b11;
            end else begin
                e.shw = 1'b1;
            end
        end
        step(tag, 1'($urandom), e);
        if (will_fault) begin
            fault_seen = 1'b1;
            for (int i = 0; i < 4; i++) begin
                e = '0;
                e.busy  = 1'b1;
                e.fault = 1'b1;
                step(tag, 1'($urandom), e);
            end
            return;
        end
        if (!goes_mem) return;
        // memory phase
        for (int i = 0; i <= mw; i++) begin
            e = '0;
            e.busy = 1'b1;
            if (is_push) begin
                e.mwr  = 1'b1;
                e.msrc = 3'b100;
                if (i == mw) begin
                    e.spw   = 1'b1;
                    e.spsrc = 2'b01;
                end
            end else if (is_peek) begin
                e.mrd  = 1'b1;
                e.msrc = 3'b101;
                if (i == mw) e.maryw = 1'b1;
            end else begin
                e.mrd  = 1'b1;
                e.msrc = 3'b100;
                if (i == mw) begin
                    e.spw   = 1'b1;
                    e.spsrc = 2'b10;
                    if (op == 5'd5) e.maryw = 1'b1;
                    else            e.raw   = 1'b1;
                end
            end
            step(tag, (i == mw), e);
        end
        if (is_push) model_depth = (model_depth < STACK_DEPTH) ? model_depth + 1 : STACK_DEPTH;
        if (is_pop)  model_depth = (model_depth > 0) ? model_depth - 1 : 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        model_depth = 0;
        fault_seen  = 1'b0;
    endtask

    task automatic test_reset();
        sig_t z;
        z = '0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (observe() !== z) begin
            errors++;
            $display("FAIL reset_hold outputs got=%h exp=%h", observe(), z);
        end
        checks++;
        if (depth !== '0) begin
            errors++;
            $display("FAIL reset_hold depth got=%0d exp=0", depth);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        // No request until the first rising edge after release.
        checks++;
        if (observe() !== z) begin
            errors++;
            $display("FAIL reset_release outputs got=%h exp=%h", observe(), z);
        end
        model_depth = 0;
    endtask

    task automatic test_aput();
        run_instr("aput_f0", OP_APUT, 1'b0, 0, 0);
        run_instr("aput_f1", OP_APUT, 1'b1, 1, 0);
        run_instr("nop_after_aput", 5'd2, 1'b0, 0, 0);
    endtask

    task automatic test_sput_wait();
        run_instr("sput_wait", OP_SPUT, 1'b0, 0, 2);
        run_instr("nop_depth1", 5'd3, 1'b0, 0, 0);
        run_instr("spek_depth1", OP_SPEK, 1'b0, 0, 1);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17 && !fault_seen; i++) run_instr("sput_fill", OP_SPUT, 1'b0, 0, 0);
        if (fault_seen) do_reset();
        else            run_instr("spek_full", OP_SPEK, 1'b0, 0, 0);
    endtask

    task automatic test_pop_empty();
        do_reset();
        run_instr("spop_empty", OP_SPOP, 1'b0, 0, 0);
        if (fault_seen) do_reset();
        run_instr("nop_after_spop", 5'd7, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        bit         push, pop;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: op = OP_APUT;
                1: op = OP_SPUT;
                2: op = OP_BKAC;
                3: op = OP_SPEK;
                4: op = OP_SPOP;
                5: op = OP_RPOP;
                6: begin
                    op = 5'($urandom_range(2, 30));
                    if (op == 5'd4 || op == 5'd5 || op == 5'd6 || op == 5'd21) op = 5'd3;
                end
                default: op = OP_SPUT;
            endcase
            push = (op == OP_SPUT) || (op == OP_BKAC);
            pop  = (op == OP_SPOP) || (op == OP_RPOP);
`ifdef STACK_BOUNDS_CHECK_EN
            if ((push && model_depth == STACK_DEPTH) || (pop && model_depth == 0)) op = 5'd2;
`endif
            run_instr("random", op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_rpop();
        sig_t e;
        sig_t z;
        z = '0;
        do_reset();
        run_instr("sput_pre", OP_SPUT, 1'b0, 0, 0);
        cur_op   = OP_RPOP;
        cur_flag = 1'b0;
        cyc_no   = 0;
        e = '0; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step("rpop_fetch", 1'b1, e);
        e = '0; e.busy = 1'b1;
        step("rpop_decode", 1'b0, e);
        step("rpop_exec", 1'b0, e);
        e = '0; e.busy = 1'b1; e.mrd = 1'b1; e.msrc = 3'b100;
        step("rpop_mem_wait", 1'b0, e);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (observe() !== z) begin
            errors++;
            $display("FAIL rpop_async_reset outputs got=%h exp=%h", observe(), z);
        end
        checks++;
        if (depth !== '0) begin
            errors++;
            $display("FAIL rpop_async_reset depth got=%0d exp=0", depth);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (RAWrite !== 1'b0) begin
                errors++;
                $display("FAIL rpop_reset_rawrite got=%b exp=0", RAWrite);
            end
        end
        @(negedge clk);
        reset       = 1'b0;
        mem_ready   = 1'b0;
        model_depth = 0;
        run_instr("aput_after_reset", OP_APUT, 1'b0, 0, 0);
    endtask

    task automatic test_halt();
        do_reset();
        run_instr("halt", OP_HALT, 1'b0, 1, 0);
        do_reset();
        run_instr("aput_after_halt", OP_APUT, 1'b1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_aput();
        test_sput_wait();
        test_saturation();
        test_pop_empty();
        test_random();
        test_reset_mid_rpop();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
